// File: rtl/bowling_scorer_mp.sv
// bowling_scorer_mp: clocked multi-player bowling scorer with incremental strike/spare bonus
// and index-selected per-frame readout.
module bowling_scorer_mp #(
  parameter int FRAMES  = 10,
  parameter int PINS    = 10,
  parameter int PLAYERS = 2,
  parameter int PIN_W   = 4,
  parameter int FRAME_W = 6,
  parameter int TOTAL_W = 11,
  localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIN_W-1:0]   pointIn,
  input  logic               button,
  input  logic [PW-1:0]      player_sel,
  input  logic [3:0]         frame_sel,
  output logic [FRAME_W-1:0] frameScore,
  output logic               frameValid,
  output logic [TOTAL_W-1:0] pointAll,
  output logic [PW-1:0]      curPlayer,
  output logic [3:0]         curFrame,
  output logic [1:0]         curRoll,
  output logic               rollAccept,
  output logic               rollError,
  output logic               gameOver
);
  logic [FRAME_W-1:0] score_q [PLAYERS][FRAMES];
  logic [FRAME_W-1:0] score_d [PLAYERS][FRAMES];
  logic [1:0]         pend_q  [PLAYERS][FRAMES];
  logic [1:0]         pend_d  [PLAYERS][FRAMES];
  logic               done_q  [PLAYERS][FRAMES];
  logic               done_d  [PLAYERS][FRAMES];
  logic [TOTAL_W-1:0] total_q [PLAYERS];
  logic [TOTAL_W-1:0] total_d [PLAYERS];
  logic [PW-1:0]      player_q, player_d;
  logic [3:0]         frame_q, frame_d;
  logic [1:0]         roll_q, roll_d;
  logic [PIN_W-1:0]   stand_q, stand_d;
  logic               over_q, over_d, acc_q, acc_d, err_q, err_d, button_q;
  logic               press, accept, strike, last_frame, last_player, frame_end;
  logic [FRAME_W-1:0] cur_score, sum2;
  logic [PIN_W-1:0]   rem;
  logic [1:0]         new_pend;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      score_q  <= '{default: '0};
      pend_q   <= '{default: '0};
      done_q   <= '{default: '0};
      total_q  <= '{default: '0};
      player_q <= '0;
      frame_q  <= 4'd1;
      roll_q   <= 2'd1;
      stand_q  <= PIN_W'(PINS);
      over_q   <= 1'b0;
      acc_q    <= 1'b0;
      err_q    <= 1'b0;
      button_q <= 1'b0;
    end else begin
      score_q  <= score_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      total_q  <= total_d;
      player_q <= player_d;
      frame_q  <= frame_d;
      roll_q   <= roll_d;
      stand_q  <= stand_d;
      over_q   <= over_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      button_q <= button;
    end

  always_comb begin
    cur_score = '0;
    for (int i = 0; i < PLAYERS; i++)
      for (int f = 0; f < FRAMES; f++)
        if (i == int'(player_q) && f == int'(frame_q) - 1) cur_score = score_q[i][f];
    press       = button && !button_q;
    accept      = press && !over_q && (pointIn <= stand_q);
    last_frame  = int'(frame_q) == FRAMES;
    last_player = int'(player_q) == PLAYERS - 1;
    strike      = roll_q == 2'd1 && pointIn == PIN_W'(PINS);
    sum2        = cur_score + FRAME_W'(pointIn);
    rem         = stand_q - pointIn;
    // The final frame's own score equals its rolls, so roll1+roll2 >= PINS means strike or spare
    frame_end   = last_frame ? (roll_q == 2'd3 || (roll_q == 2'd2 && sum2 < FRAME_W'(PINS)))
                             : (strike || roll_q == 2'd2);
    new_pend    = last_frame ? 2'd0 : strike ? 2'd2
                : (roll_q == 2'd2 && sum2 == FRAME_W'(PINS)) ? 2'd1 : 2'd0;
    score_d  = score_q;
    pend_d   = pend_q;
    done_d   = done_q;
    total_d  = total_q;
    player_d = player_q;
    frame_d  = frame_q;
    roll_d   = roll_q;
    stand_d  = stand_q;
    over_d   = over_q;
    acc_d    = accept;
    err_d    = press && !accept;
    if (accept) begin
      for (int i = 0; i < PLAYERS; i++)
        if (i == int'(player_q))
          for (int f = 0; f < FRAMES; f++)
            if (f == int'(frame_q) - 1) begin
              score_d[i][f] = score_q[i][f] + FRAME_W'(pointIn);
              pend_d[i][f]  = new_pend;
              done_d[i][f]  = frame_end;
              total_d[i]    = total_d[i] + TOTAL_W'(pointIn);
            end else if (pend_q[i][f] != 2'd0) begin
              score_d[i][f] = score_q[i][f] + FRAME_W'(pointIn);
              pend_d[i][f]  = pend_q[i][f] - 2'd1;
              total_d[i]    = total_d[i] + TOTAL_W'(pointIn);
            end
      stand_d = (frame_end || rem == '0) ? PIN_W'(PINS) : rem;
      roll_d  = frame_end ? 2'd1 : roll_q + 2'd1;
      if (frame_end) begin
        if (!last_player) player_d = player_q + PW'(1);
        else if (!last_frame) begin
          player_d = '0;
          frame_d  = frame_q + 4'd1;
        end else begin
          over_d = 1'b1;
          roll_d = roll_q;
        end
      end
    end
  end

  always_comb begin
    frameScore = '0;
    frameValid = 1'b0;
    pointAll   = '0;
    for (int i = 0; i < PLAYERS; i++)
      if (i == int'(player_sel)) begin
        pointAll = total_q[i];
        for (int f = 0; f < FRAMES; f++)
          if (f == int'(frame_sel) - 1) begin
            frameScore = score_q[i][f];
            frameValid = done_q[i][f] && pend_q[i][f] == 2'd0;
          end
      end
  end

  assign curPlayer  = player_q;
  assign curFrame   = frame_q;
  assign curRoll    = roll_q;
  assign rollAccept = acc_q;
  assign rollError  = err_q;
  assign gameOver   = over_q;
endmodule
